// File: rtl/line_buffer_3row.sv
// line_buffer_3row: 4-row circular line store feeding a 3x3 convolution stage.
// Pixels arrive in raster order through a valid/ready port. Once three complete
// rows are stored, the consumer pulls one vertically aligned 3-pixel column per
// shift_buffer request and retires the top row with row_advance. The spare
// fourth slot lets the next image row fill while the current window is read.
module line_buffer_3row #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_WIDTH = 16,
    parameter int COL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_clr,
    input  logic [BIT_DEPTH-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 shift_buffer,
    input  logic                 row_advance,
    output logic [BIT_DEPTH-1:0] in_l1,
    output logic [BIT_DEPTH-1:0] in_l2,
    output logic [BIT_DEPTH-1:0] in_l3,
    output logic                 col_valid,
    output logic                 col_last,
    output logic                 win_ready,
    output logic                 underrun
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    // Read side state is implied by the stored-row count, not held in its own flop.
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Line store: four row slots, no reset (contents are don't-care until written).
    logic [BIT_DEPTH-1:0] mem_q [0:3][0:IMG_WIDTH-1];

    logic [1:0]           wr_row_q,   wr_row_d;
    logic [COL_W-1:0]     wr_col_q,   wr_col_d;
    logic [1:0]           rd_base_q,  rd_base_d;
    logic [COL_W-1:0]     rd_col_q,   rd_col_d;
    logic [2:0]           rows_cnt_q, rows_cnt_d;
    logic [BIT_DEPTH-1:0] in_l1_q,    in_l1_d;
    logic [BIT_DEPTH-1:0] in_l2_q,    in_l2_d;
    logic [BIT_DEPTH-1:0] in_l3_q,    in_l3_d;
    logic                 col_valid_q, col_valid_d;
    logic                 col_last_q,  col_last_d;
    logic                 underrun_q,  underrun_d;

    rd_state_e            rd_state_s;
    logic                 pix_ready_s;
    logic                 win_ready_s;
    logic                 wr_en_s;
    logic                 row_done_s;
    logic                 adv_fire_s;
    logic [1:0]           rd_row1_s;
    logic [1:0]           rd_row2_s;

    assign pix_ready_s = (rows_cnt_q < 3'd4);
    assign win_ready_s = (rows_cnt_q >= 3'd3);
    assign rd_state_s  = win_ready_s ? RD_STREAM : RD_IDLE;
    assign rd_row1_s   = rd_base_q + 2'd1;
    assign rd_row2_s   = rd_base_q + 2'd2;

    // Next-state logic for write pointers, read pointers, row count and output column.
    always_comb begin
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        rd_base_d   = rd_base_q;
        rd_col_d    = rd_col_q;
        rows_cnt_d  = rows_cnt_q;
        in_l1_d     = in_l1_q;
        in_l2_d     = in_l2_q;
        in_l3_d     = in_l3_q;
        col_valid_d = 1'b0;
        col_last_d  = 1'b0;
        underrun_d  = underrun_q;
        wr_en_s     = 1'b0;
        row_done_s  = 1'b0;
        adv_fire_s  = 1'b0;

        if (frame_clr) begin
            // Clear wins over any same-cycle pixel or read request.
            wr_row_d   = 2'd0;
            wr_col_d   = {COL_W{1'b0}};
            rd_base_d  = 2'd0;
            rd_col_d   = {COL_W{1'b0}};
            rows_cnt_d = 3'd0;
            in_l1_d    = {BIT_DEPTH{1'b0}};
            in_l2_d    = {BIT_DEPTH{1'b0}};
            in_l3_d    = {BIT_DEPTH{1'b0}};
            underrun_d = 1'b0;
        end else begin
            // Write side: slot wr_row is never part of the read window while not full.
            if (pix_valid && pix_ready_s) begin
                wr_en_s = 1'b1;
                if (wr_col_q == LAST_COL) begin
                    wr_col_d   = {COL_W{1'b0}};
                    wr_row_d   = wr_row_q + 2'd1;
                    row_done_s = 1'b1;
                end else begin
                    wr_col_d   = wr_col_q + {{(COL_W-1){1'b0}}, 1'b1};
                end
            end else begin
                wr_en_s = 1'b0;
            end

            // Read side: row_advance outranks shift_buffer; any request without a window underruns.
            case (rd_state_s)
                RD_IDLE: begin
                    if (shift_buffer || row_advance) begin
                        underrun_d = 1'b1;
                    end else begin
                        underrun_d = underrun_q;
                    end
                end
                RD_STREAM: begin
                    if (row_advance) begin
                        adv_fire_s = 1'b1;
                        rd_base_d  = rd_base_q + 2'd1;
                        rd_col_d   = {COL_W{1'b0}};
                    end else if (shift_buffer) begin
                        in_l1_d     = mem_q[rd_base_q][rd_col_q];
                        in_l2_d     = mem_q[rd_row1_s][rd_col_q];
                        in_l3_d     = mem_q[rd_row2_s][rd_col_q];
                        col_valid_d = 1'b1;
                        if (rd_col_q == LAST_COL) begin
                            col_last_d = 1'b1;
                            rd_col_d   = {COL_W{1'b0}};
                        end else begin
                            col_last_d = 1'b0;
                            rd_col_d   = rd_col_q + {{(COL_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        rd_col_d = rd_col_q;
                    end
                end
                default: begin
                    underrun_d = underrun_q;
                end
            endcase

            // Completed row in and retired row out in the same cycle cancel out.
            rows_cnt_d = rows_cnt_q + {2'b00, row_done_s} - {2'b00, adv_fire_s};
        end
    end

    // Pointer, count and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_row_q    <= 2'd0;
            wr_col_q    <= {COL_W{1'b0}};
            rd_base_q   <= 2'd0;
            rd_col_q    <= {COL_W{1'b0}};
            rows_cnt_q  <= 3'd0;
            in_l1_q     <= {BIT_DEPTH{1'b0}};
            in_l2_q     <= {BIT_DEPTH{1'b0}};
            in_l3_q     <= {BIT_DEPTH{1'b0}};
            col_valid_q <= 1'b0;
            col_last_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            wr_row_q    <= wr_row_d;
            wr_col_q    <= wr_col_d;
            rd_base_q   <= rd_base_d;
            rd_col_q    <= rd_col_d;
            rows_cnt_q  <= rows_cnt_d;
            in_l1_q     <= in_l1_d;
            in_l2_q     <= in_l2_d;
            in_l3_q     <= in_l3_d;
            col_valid_q <= col_valid_d;
            col_last_q  <= col_last_d;
            underrun_q  <= underrun_d;
        end
    end

    // Line store write port; data is left untouched by reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_row_q][wr_col_q] <= pix_in;
        end
    end

    assign pix_ready = pix_ready_s;
    assign win_ready = win_ready_s;
    assign in_l1     = in_l1_q;
    assign in_l2     = in_l2_q;
    assign in_l3     = in_l3_q;
    assign col_valid = col_valid_q;
    assign col_last  = col_last_q;
    assign underrun  = underrun_q;

endmodule
